// File: rtl/stim_pkg.sv
// Shared types and defaults for the stimulus player / MISR compactor.
package stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } stim_state_t;

  // Vector entry at the default 8-bit stimulus / 8-bit hold widths.
  typedef struct packed {
    logic [7:0] hold;
    logic [7:0] data;
  } stim_entry_t;

  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;

endpackage

// File: rtl/misr.sv
// Multiple-input signature register: Galois-style shift with feedback POLY,
// XORing the parallel input word into every update.
module misr #(
  parameter int unsigned      OUT_W = 8,
  parameter logic [OUT_W-1:0] POLY  = 8'h1D,
  parameter logic [OUT_W-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] sig
);

  // Signature register: reset/clear to SEED, otherwise compact din when enabled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ din;
    end
  end

endmodule

// File: rtl/stim_player_misr.sv
// Stimulus player: replays a loadable list of {hold, data} vectors onto the
// design inputs while compacting the design outputs into a MISR signature.
module stim_player_misr
  import stim_pkg::*;
#(
  parameter int unsigned      IN_W   = 8,
  parameter int unsigned      OUT_W  = 8,
  parameter int unsigned      DEPTH  = 16,
  parameter int unsigned      HOLD_W = 8,
  parameter logic [OUT_W-1:0] POLY   = OUT_W'(DEF_POLY),
  parameter logic [OUT_W-1:0] SEED   = OUT_W'(DEF_SEED)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [IN_W-1:0]          load_data,
  input  logic [HOLD_W-1:0]        load_hold,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_vectors,
  input  logic                     loop,
  input  logic                     abort,
  input  logic [OUT_W-1:0]         dut_out,
  output logic [IN_W-1:0]          stim_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] vec_idx,
  output logic [OUT_W-1:0]         signature
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [HOLD_W-1:0] hold;
    logic [IN_W-1:0]   data;
  } entry_t;

  entry_t            mem [DEPTH];
  stim_state_t       state, state_next;
  logic [HOLD_W-1:0] cnt;
  logic [AW:0]       n_lat;
  logic              loop_lat;
  logic              vec_expire, vec_last, start_take;
  logic [AW-1:0]     idx_next;

  // A hold of zero still plays the vector for one cycle.
  function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  // Vector memory: synchronous write, blocked while playing.
  always_ff @(posedge clk) begin
    if (load_en && state != PLAY) begin
      mem[load_addr] <= {load_hold, load_data};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and vector sequencing decisions.
  always_comb begin
    state_next = state;
    start_take = 1'b0;
    vec_expire = (cnt == HOLD_W'(1));
    vec_last   = ({1'b0, vec_idx} == (n_lat - 1'b1));
    idx_next   = vec_last ? '0 : vec_idx + 1'b1;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_take = 1'b1;
          state_next = (num_vectors == '0) ? DONE : PLAY;
        end
      end
      PLAY: begin
        if (abort || (vec_expire && vec_last && !loop_lat)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output and playback datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stim_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      vec_idx  <= '0;
      cnt      <= '0;
      n_lat    <= '0;
      loop_lat <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_lat    <= num_vectors;
            loop_lat <= loop;
            vec_idx  <= '0;
            done     <= (num_vectors == '0);
            if (num_vectors != '0) begin
              busy     <= 1'b1;
              stim_out <= mem[0].data;
              cnt      <= eff_hold(mem[0].hold);
            end
          end
        end
        PLAY: begin
          if (state_next == DONE) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            stim_out <= '0;
          end else if (vec_expire) begin
            vec_idx  <= idx_next;
            stim_out <= mem[idx_next].data;
            cnt      <= eff_hold(mem[idx_next].hold);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  misr #(
    .OUT_W (OUT_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clear (start_take),
    .en    (state == PLAY),
    .din   (dut_out),
    .sig   (signature)
  );

endmodule

// File: tb/tb_stim_player_misr.sv
// Self-checking bench for stim_player_misr: table-driven single-vector runs,
// hand-written multi-cycle sequences and randomized playback against a model.
module tb_stim_player_misr;

  localparam int IN_W   = 8;
  localparam int OUT_W  = 8;
  localparam int DEPTH  = 16;
  localparam int HOLD_W = 8;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [OUT_W-1:0] POLY = 8'h1D;
  localparam logic [OUT_W-1:0] SEED = 8'h00;

  logic              clk = 1'b0;
  logic              reset, load_en, start, loop, abort;
  logic [AW-1:0]     load_addr;
  logic [IN_W-1:0]   load_data;
  logic [HOLD_W-1:0] load_hold;
  logic [AW:0]       num_vectors;
  logic [OUT_W-1:0]  dut_out;
  logic [IN_W-1:0]   stim_out;
  logic              busy, done;
  logic [AW-1:0]     vec_idx;
  logic [OUT_W-1:0]  signature;

  always #5 clk = ~clk;

  stim_player_misr #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_hold   (load_hold),
    .start       (start),
    .num_vectors (num_vectors),
    .loop        (loop),
    .abort       (abort),
    .dut_out     (dut_out),
    .stim_out    (stim_out),
    .busy        (busy),
    .done        (done),
    .vec_idx     (vec_idx),
    .signature   (signature)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [IN_W-1:0]   sh_data [DEPTH];
  logic [HOLD_W-1:0] sh_hold [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Signature as polynomial arithmetic: multiply by x modulo x^OUT_W + POLY,
  // then add the response word.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
    logic [OUT_W:0] wide;
    wide = {s, 1'b0};
    if (wide[OUT_W]) wide[OUT_W-1:0] = wide[OUT_W-1:0] ^ POLY;
    return wide[OUT_W-1:0] ^ d;
  endfunction

  task automatic load_entry(input int addr, input logic [HOLD_W-1:0] h, input logic [IN_W-1:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(addr); load_hold = h; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    sh_data[addr] = d;
    sh_hold[addr] = h;
  endtask

  // Non-looping playback of the first n shadow entries, checked cycle by cycle.
  task automatic play(input int n, input bit inject, input string tag);
    logic [IN_W-1:0]  es[$];
    int               ei[$];
    logic [OUT_W-1:0] sig;
    int bad_s, bad_i, bad_b, reps;
    bad_s = 0; bad_i = 0; bad_b = 0;
    for (int k = 0; k < n; k++) begin
      reps = (sh_hold[k] == '0) ? 1 : int'(sh_hold[k]);
      for (int r = 0; r < reps; r++) begin
        es.push_back(sh_data[k]);
        ei.push_back(k);
      end
    end
    sig = SEED;
    @(negedge clk);
    start = 1'b1; num_vectors = (AW+1)'(n); loop = 1'b0; dut_out = OUT_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    foreach (es[c]) begin
      if (busy !== 1'b1) bad_b++;
      if (stim_out !== es[c]) bad_s++;
      if (int'(vec_idx) != ei[c]) bad_i++;
      if (inject && c == 0) begin
        load_en = 1'b1; load_addr = AW'(1); load_data = ~sh_data[1]; load_hold = 8'd7;
        start = 1'b1; num_vectors = (AW+1)'(1);
      end else begin
        load_en = 1'b0; start = 1'b0;
      end
      dut_out = OUT_W'($urandom);
      sig = misr_step(sig, dut_out);
      @(negedge clk);
    end
    load_en = 1'b0; start = 1'b0;
    check({tag, "_busy_run"}, bad_b, 0);
    check({tag, "_stim_seq"}, bad_s, 0);
    check({tag, "_idx_seq"},  bad_i, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_done"},     done, 1);
    check({tag, "_stim_zero"}, stim_out, 0);
    check({tag, "_sig"},      signature, sig);
  endtask

  typedef struct {
    logic [HOLD_W-1:0] hold;
    logic [IN_W-1:0]   data;
    logic [OUT_W-1:0]  dout;
    int                len;
    logic [OUT_W-1:0]  sig;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [OUT_W-1:0] sig;
    logic [IN_W-1:0]  seq_s [4];
    int               seq_i [4];
    int               len, bad;

    tbl[0] = '{hold: 8'd3, data: 8'h5A, dout: 8'h00, len: 3, sig: 8'h00};
    tbl[1] = '{hold: 8'd0, data: 8'h5A, dout: 8'h00, len: 1, sig: 8'h00};
    tbl[2] = '{hold: 8'd2, data: 8'hC3, dout: 8'hA5, len: 2, sig: 8'hF2};
    tbl[3] = '{hold: 8'd1, data: 8'h11, dout: 8'h3C, len: 1, sig: 8'h3C};
    tbl[4] = '{hold: 8'd3, data: 8'h77, dout: 8'h01, len: 3, sig: 8'h07};
    tbl[5] = '{hold: 8'd4, data: 8'hE1, dout: 8'h80, len: 4, sig: 8'hD3};

    reset = 1'b1; load_en = 1'b0; start = 1'b0; loop = 1'b0; abort = 1'b0;
    load_addr = '0; load_data = '0; load_hold = '0; num_vectors = '0; dut_out = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stim", stim_out, 0);
    check("rst_idx",  vec_idx, 0);
    check("rst_sig",  signature, SEED);
    reset = 1'b0;

    // Single-vector hold counts and MISR arithmetic.
    for (int t = 0; t < 6; t++) begin
      load_entry(0, tbl[t].hold, tbl[t].data);
      @(negedge clk);
      start = 1'b1; num_vectors = (AW+1)'(1); loop = 1'b0; dut_out = tbl[t].dout;
      @(negedge clk);
      start = 1'b0;
      len = 0; bad = 0;
      if (t == 2) check("tbl_sig_cycle1", signature, 8'h00);
      while (busy === 1'b1 && len < 40) begin
        if (stim_out !== tbl[t].data) bad++;
        len++;
        @(negedge clk);
        if (t == 2 && len == 1) check("tbl_sig_after1", signature, 8'hA5);
      end
      check($sformatf("tbl%0d_len", t), len, tbl[t].len);
      check($sformatf("tbl%0d_stim", t), bad, 0);
      check($sformatf("tbl%0d_done", t), done, 1);
      check($sformatf("tbl%0d_zero", t), stim_out, 0);
      check($sformatf("tbl%0d_sig", t), signature, tbl[t].sig);
    end

    // Three-vector sequencing with no bubbles.
    load_entry(0, 8'd1, 8'h01);
    load_entry(1, 8'd2, 8'h02);
    load_entry(2, 8'd1, 8'h03);
    seq_s = '{8'h01, 8'h02, 8'h02, 8'h03};
    seq_i = '{0, 1, 1, 2};
    @(negedge clk);
    start = 1'b1; num_vectors = (AW+1)'(3); loop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (stim_out !== seq_s[c] || int'(vec_idx) != seq_i[c] || busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("seq_cycles", bad, 0);
    check("seq_busy_end", busy, 0);
    check("seq_done", done, 1);

    // Looping playback aborted on its fifth cycle.
    load_entry(0, 8'd1, 8'hAA);
    load_entry(1, 8'd1, 8'hBB);
    @(negedge clk);
    start = 1'b1; num_vectors = (AW+1)'(2); loop = 1'b1;
    @(negedge clk);
    start = 1'b0; loop = 1'b0;
    sig = SEED; bad = 0;
    for (int c = 1; c <= 5; c++) begin
      if (int'(vec_idx) != (c - 1) % 2 || busy !== 1'b1) bad++;
      dut_out = OUT_W'($urandom);
      sig = misr_step(sig, dut_out);
      abort = (c == 5);
      @(negedge clk);
    end
    abort = 1'b0;
    check("loop_idx", bad, 0);
    check("abort_done", done, 1);
    check("abort_busy", busy, 0);
    check("abort_sig", signature, sig);
    repeat (3) begin
      dut_out = OUT_W'($urandom);
      @(negedge clk);
    end
    check("abort_sig_frozen", signature, sig);
    check("abort_done_sticky", done, 1);

    // Zero-length run goes straight to DONE with the seed signature.
    @(negedge clk);
    start = 1'b1; num_vectors = '0;
    @(negedge clk);
    start = 1'b0;
    check("n0_done", done, 1);
    check("n0_busy", busy, 0);
    check("n0_sig",  signature, SEED);
    check("n0_stim", stim_out, 0);

    // Randomized playback, including full depth and writes/starts during PLAY.
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < DEPTH; a++)
        load_entry(a, HOLD_W'($urandom_range(0, 3)), IN_W'($urandom));
      play((it == 0) ? DEPTH : $urandom_range(1, DEPTH), (it == 1 || it == 3),
           $sformatf("rnd%0d", it));
    end
    // Entry 1 must still hold the data from before the ignored write.
    sh_hold[0] = 8'd1;
    load_entry(0, 8'd1, 8'h3E);
    play(2, 1'b0, "after_inject");

    // Reset in the middle of playback.
    load_entry(0, 8'd9, 8'h66);
    @(negedge clk);
    start = 1'b1; num_vectors = (AW+1)'(1); dut_out = 8'h5C;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_stim", stim_out, 0);
    check("midrst_idx",  vec_idx, 0);
    check("midrst_sig",  signature, SEED);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
